// File: rtl/mha_pkg.sv
// mha_pkg: shared definitions for the attention datapath blocks.
//   DATA_W / FRAC_W : Q2.13 sample format (16-bit signed, 13 fractional bits)
//   SA_COLS         : number of systolic-array output lanes
//   sa_state_e      : control states of the output deskew collector
package mha_pkg;

  localparam int DATA_W  = 16;
  localparam int FRAC_W  = 13;
  localparam int SA_COLS = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } sa_state_e;

endpackage

// File: rtl/sa_col_capture.sv
// sa_col_capture: result buffer for one systolic-array output column.
//   Ports:
//     clk      : clock, rising edge
//     rst      : synchronous active-high reset, clears the buffer
//     shift_en : qualified shift strobe (already gated by the collector FSM)
//     k        : current shift index
//     din      : this column's lane sample
//     col_out  : X_R words, row r at col_out[r*DATA_W +: DATA_W]
//   On a strobe, the lane holds row r = k - S - C; rows outside [0, X_R)
//   are skew padding and are dropped.
module sa_col_capture
  import mha_pkg::*;
#(
  parameter int S   = 64,
  parameter int X_R = 64,
  parameter int C   = 0,
  parameter int KW  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     shift_en,
  input  logic [KW-1:0]            k,
  input  logic signed [DATA_W-1:0] din,
  output logic [X_R*DATA_W-1:0]    col_out
);

  localparam int unsigned R_LO = S + C;

  logic signed [DATA_W-1:0] col_q [X_R];
  logic signed [DATA_W-1:0] col_d [X_R];
  logic [31:0]              k_ext;
  logic [31:0]              r_ext;
  logic                     hit;

  always_comb begin
    k_ext = 32'(k);
    // Unsigned subtraction wraps below R_LO; the lower-bound test rejects those.
    r_ext = k_ext - R_LO;
    hit   = shift_en && (k_ext >= R_LO) && (r_ext < 32'(X_R));
    for (int i = 0; i < X_R; i++) begin
      col_d[i] = col_q[i];
      if (hit && (r_ext == 32'(i))) begin
        col_d[i] = din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < X_R; i++) begin
        col_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < X_R; i++) begin
        col_q[i] <= col_d[i];
      end
    end
  end

  for (genvar gi = 0; gi < X_R; gi++) begin : g_row
    assign col_out[gi*DATA_W +: DATA_W] = col_q[gi];
  end

endmodule

// File: rtl/sa_out_deskew.sv
// sa_out_deskew: collects the time-skewed result stream leaving the bottom of
// the systolic array and presents the full X_R x N result matrix as one bus.
//   Ports:
//     I_CLK        : clock, rising edge
//     I_RST        : synchronous active-high reset
//     I_START_FLAG : restart collection at shift index 0, drops O_OUT_VLD
//     I_SHIFT      : PE shift strobe; I_SA_OUT sampled when high in COLLECT
//     I_SA_OUT     : N lanes of 16-bit Q2.13, lane c at [c*16 +: 16]
//     O_BUSY       : high while collecting
//     O_OUT_VLD    : high from matrix completion until next start/reset
//     O_OUT        : Y[r][c] at [(r*N+c)*16 +: 16]
module sa_out_deskew
  import mha_pkg::*;
#(
  parameter int S   = 64,
  parameter int X_R = 64,
  parameter int N   = SA_COLS
) (
  input  logic                      I_CLK,
  input  logic                      I_RST,
  input  logic                      I_START_FLAG,
  input  logic                      I_SHIFT,
  input  logic [N*DATA_W-1:0]       I_SA_OUT,
  output logic                      O_BUSY,
  output logic                      O_OUT_VLD,
  output logic [X_R*N*DATA_W-1:0]   O_OUT
);

  localparam int KW     = $clog2(S + X_R + N);
  localparam int K_LAST = S + X_R + N - 2;

  sa_state_e     state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic          busy_q, busy_d;
  logic          vld_q, vld_d;
  logic          shift_en;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    shift_en = 1'b0;
    // Start has priority over everything, including a same-cycle shift.
    if (I_START_FLAG) begin
      state_d = COLLECT;
      k_d     = '0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (I_SHIFT) begin
            shift_en = 1'b1;
            if (k_q == KW'(K_LAST)) begin
              state_d = DONE;
            end else begin
              k_d = k_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
    busy_d = (state_d == COLLECT);
    vld_d  = (state_d == DONE);
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_q <= IDLE;
      k_q     <= '0;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      vld_q   <= vld_d;
    end
  end

  assign O_BUSY    = busy_q;
  assign O_OUT_VLD = vld_q;

  logic [X_R*DATA_W-1:0] col_bus [N];

  for (genvar gc = 0; gc < N; gc++) begin : g_col
    logic signed [DATA_W-1:0] lane;
    assign lane = I_SA_OUT[gc*DATA_W +: DATA_W];

    sa_col_capture #(
      .S   (S),
      .X_R (X_R),
      .C   (gc),
      .KW  (KW)
    ) u_cap (
      .clk      (I_CLK),
      .rst      (I_RST),
      .shift_en (shift_en),
      .k        (k_q),
      .din      (lane),
      .col_out  (col_bus[gc])
    );

    for (genvar gr = 0; gr < X_R; gr++) begin : g_flat
      assign O_OUT[(gr*N+gc)*DATA_W +: DATA_W] = col_bus[gc][gr*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_sa_out_deskew.sv
// tb_sa_out_deskew: randomized bench for sa_out_deskew (S=4, X_R=3, N=4)
// with a behavioural result-matrix model and a per-cycle compare process.
module tb_sa_out_deskew;

  localparam int S     = 4;
  localparam int XR    = 3;
  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int KLAST = S + XR + N - 2;
  localparam int OW    = XR * N * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          shift;
  logic [N*DW-1:0] sa_out;
  logic          busy;
  logic          vld;
  logic [OW-1:0] out;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: result matrix, collecting/done flags, pulse count.
  logic [DW-1:0] m_y [XR][N];
  bit            m_col;
  bit            m_done;
  int            m_k;
  bit            chk_en = 1'b0;

  logic [OW-1:0] snap;

  sa_out_deskew #(.S(S), .X_R(XR), .N(N)) dut (
    .I_CLK        (clk),
    .I_RST        (rst),
    .I_START_FLAG (start),
    .I_SHIFT      (shift),
    .I_SA_OUT     (sa_out),
    .O_BUSY       (busy),
    .O_OUT_VLD    (vld),
    .O_OUT        (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] model_flat();
    logic [OW-1:0] f;
    f = '0;
    for (int r = 0; r < XR; r++)
      for (int c = 0; c < N; c++)
        f[(r*N+c)*DW +: DW] = m_y[r][c];
    return f;
  endfunction

  function automatic logic [DW-1:0] word(input logic [OW-1:0] bus, input int r, input int c);
    return bus[(r*N+c)*DW +: DW];
  endfunction

  // Lane c on pulse k carries Y[k-S-c][c] when that row exists, filler otherwise.
  function automatic logic [N*DW-1:0] lanes(input int k, input int base, input bit rnd);
    logic [N*DW-1:0] v;
    int r;
    for (int c = 0; c < N; c++) begin
      r = k - S - c;
      if (r >= 0 && r < XR) v[c*DW +: DW] = 16'((base << 8) | (r << 4) | c);
      else                  v[c*DW +: DW] = rnd ? 16'($urandom) : 16'hDEAD;
    end
    return v;
  endfunction

  // Behavioural model: matrix slot written by the pulse that carries it.
  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < XR; r++)
        for (int c = 0; c < N; c++)
          m_y[r][c] <= '0;
      m_col  <= 1'b0;
      m_done <= 1'b0;
      m_k    <= 0;
    end else if (start) begin
      m_col  <= 1'b1;
      m_done <= 1'b0;
      m_k    <= 0;
    end else if (m_col && shift) begin
      for (int c = 0; c < N; c++) begin
        if (m_k - S - c >= 0 && m_k - S - c < XR)
          m_y[m_k - S - c][c] <= sa_out[c*DW +: DW];
      end
      if (m_k == KLAST) begin
        m_col  <= 1'b0;
        m_done <= 1'b1;
      end else begin
        m_k <= m_k + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_out", out, model_flat());
      check("cyc_vld", OW'(vld), OW'(m_done));
      check("cyc_busy", OW'(busy), OW'(m_col));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input bit with_shift, input logic [N*DW-1:0] data);
    start  = 1'b1;
    shift  = with_shift;
    sa_out = data;
    tick();
    start  = 1'b0;
    shift  = 1'b0;
  endtask

  task automatic do_pulses(input int k0, input int n, input int gmin, input int gmax,
                           input int base, input bit rnd);
    int g;
    for (int i = 0; i < n; i++) begin
      g = int'($urandom_range(gmax, gmin));
      repeat (g) begin
        shift  = 1'b0;
        sa_out = {$urandom, $urandom};
        tick();
      end
      shift  = 1'b1;
      sa_out = lanes(k0 + i, base, rnd);
      tick();
      shift  = 1'b0;
    end
  endtask

  initial begin
    int dead_cnt;
    int n;
    rst = 1'b1; start = 1'b0; shift = 1'b0; sa_out = '0;
    tick();
    chk_en = 1'b1;
    // Reset must override a concurrent start and shift.
    start = 1'b1; shift = 1'b1; sa_out = lanes(S, 7, 0);
    tick();
    rst = 1'b0; start = 1'b0; shift = 1'b0;
    check("rst_out", out, '0);
    check("rst_vld", OW'(vld), '0);
    check("rst_busy", OW'(busy), '0);
    tick();

    // Nominal back-to-back run with DEAD filler.
    do_start(1'b0, '0);
    check("start_busy", OW'(busy), OW'(1));
    do_pulses(0, KLAST, 0, 0, 0, 1'b0);
    check("nom_vld_before_last", OW'(vld), '0);
    do_pulses(KLAST, 1, 0, 0, 0, 1'b0);
    check("nom_vld", OW'(vld), OW'(1));
    check("nom_busy", OW'(busy), '0);
    dead_cnt = 0;
    for (int r = 0; r < XR; r++)
      for (int c = 0; c < N; c++) begin
        check($sformatf("nom_y%0d%0d", r, c), OW'(word(out, r, c)), OW'((r << 4) | c));
        if (word(out, r, c) == 16'hDEAD) dead_cnt++;
      end
    check("nom_no_dead", OW'(dead_cnt), '0);
    snap = out;
    tick();

    // Shift only every 5th cycle.
    do_start(1'b0, '0);
    do_pulses(0, KLAST + 1, 4, 4, 0, 1'b0);
    check("gap_out", out, snap);
    check("gap_vld", OW'(vld), OW'(1));

    // Extra pulses after completion must not disturb the result.
    for (int i = 0; i < 20; i++) begin
      shift = 1'b1; sa_out = {$urandom, $urandom};
      tick();
    end
    shift = 1'b0;
    check("hold_out", out, snap);
    check("hold_vld", OW'(vld), OW'(1));

    // Restart mid-run with new data.
    do_start(1'b0, '0);
    check("restart_vld_drop", OW'(vld), '0);
    do_pulses(0, 5, 0, 1, 1, 1'b1);
    do_start(1'b0, '0);
    do_pulses(0, KLAST, 0, 1, 2, 1'b1);
    check("restart_vld_low", OW'(vld), '0);
    do_pulses(KLAST, 1, 0, 0, 2, 1'b1);
    check("restart_vld", OW'(vld), OW'(1));
    check("restart_y00", OW'(word(out, 0, 0)), OW'(16'h0200));
    check("restart_y23", OW'(word(out, 2, 3)), OW'(16'h0223));

    // Start and shift together: the shift is dropped.
    do_start(1'b1, lanes(0, 3, 0));
    do_pulses(0, KLAST, 0, 0, 3, 1'b0);
    check("sim_vld_low", OW'(vld), '0);
    do_pulses(KLAST, 1, 0, 0, 3, 1'b0);
    check("sim_vld", OW'(vld), OW'(1));
    check("sim_y23", OW'(word(out, 2, 3)), OW'(16'h0323));

    // Reset mid-collect, then shifts are ignored.
    do_start(1'b0, '0);
    do_pulses(0, 5, 0, 0, 5, 1'b0);
    rst = 1'b1; start = 1'b1; shift = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0; shift = 1'b0;
    check("mrst_out", out, '0);
    check("mrst_vld", OW'(vld), '0);
    check("mrst_busy", OW'(busy), '0);
    do_pulses(0, KLAST + 2, 0, 0, 6, 1'b0);
    check("mrst_idle_out", out, '0);
    check("mrst_idle_busy", OW'(busy), '0);

    // Random runs, some cut short by the next start.
    for (int run = 0; run < 40; run++) begin
      do_start($urandom_range(1, 0) == 1, {$urandom, $urandom});
      n = int'($urandom_range(KLAST + 4, 3));
      do_pulses(0, n, 0, 3, run & 8'hff, 1'b1);
      repeat ($urandom_range(3, 0)) begin
        sa_out = {$urandom, $urandom};
        tick();
      end
    end

    tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sa_out_deskew.md
# sa_out_deskew

Output-side counterpart of the systolic-array input skewer. It samples the 64-lane, time-skewed result stream that shifts out of the bottom of the systolic array, one sample per PE shift pulse. It writes each sample into its (row, column) slot of a result buffer and presents the complete (X_R, N) product matrix as one flat bus with a level-valid flag. It sits between the SA core's shift/output pins and the attention datapath consumer, for example softmax or the next projection.

## Interface
- S, 64: array depth (rows of W); sets the fixed pipeline offset D = S.
- X_R, 64: rows of X, which is also the number of result rows.
- N, 64: result columns, equal to the number of SA output lanes.
- I_CLK  in  1: clock, rising edge.
- I_RST  in  1: synchronous, active-high reset.
- I_START_FLAG  in  1: one-cycle pulse issued with the SA start. Clears the shift counter and drops O_OUT_VLD.
- I_SHIFT  in  1: PE shift strobe from the SA. I_SA_OUT is sampled on every cycle where it is high.
- I_SA_OUT  in  N*16: bottom-of-array outputs; lane c is I_SA_OUT[c*16 +: 16].
- O_BUSY  out  1: high while in COLLECT.
- O_OUT_VLD  out  1: high from matrix completion until the next start or reset.
- O_OUT  out  X_R*N*16: Y[r][c] is at O_OUT[(r*N+c)*16 +: 16].

## Operation
- Data format: 16-bit signed Q2.13, passed through unmodified; no arithmetic on data.
- Shift index k counts I_SHIFT pulses in COLLECT, starting at 0. The counter width is $clog2(S+X_R+N).
- Skew rule: on pulse k, lane c carries Y[r][c] with r = k − S − c. It is captured only if 0 ≤ r < X_R; otherwise the lane is ignored.
- Final useful pulse: k_last = S + X_R − 1 + N − 1.
- States:
  - IDLE: I_SHIFT is ignored. I_START_FLAG moves to COLLECT with k=0.
  - COLLECT: each I_SHIFT captures all valid lanes in parallel and then increments k. The capture at k = k_last moves to DONE.
  - DONE: O_OUT_VLD = 1 and O_OUT holds stable. I_SHIFT is ignored. I_START_FLAG moves to COLLECT with k=0 and O_OUT_VLD=0.
- I_START_FLAG in any state, including mid-COLLECT, restarts at k=0. Partial data is not cleared; it is overwritten, because a full run writes every slot exactly once.
- If I_START_FLAG and I_SHIFT are high in the same cycle, start wins and the shift is dropped.
- Extra I_SHIFT pulses after k_last, which the SA keeps emitting until its end flag, have no effect.

## Timing
- Reset, checked the cycle after I_RST is sampled high: state IDLE, k=0, O_BUSY=0, O_OUT_VLD=0, O_OUT all zeros. Reset overrides start and shift.
- Capture: a sample present on I_SA_OUT in a cycle with I_SHIFT=1 appears on O_OUT after the next rising edge, so write latency is 1 cycle.
- O_OUT_VLD rises at the same edge that registers the k_last capture. O_OUT is therefore complete in the first cycle that VLD is high.
- O_BUSY rises at the edge that samples I_START_FLAG and falls together with the VLD rise.
- No backpressure: the consumer must read O_OUT before issuing the next I_START_FLAG. VLD falls at the edge that samples the start.
- k never wraps: in COLLECT it saturates at k_last.

## Structure
- Shared package `mha_pkg`:
  - DATA_W = 16, FRAC_W = 13.
  - SA_COLS = 64.
  - The state enum: IDLE, COLLECT, DONE.
- One natural sub-module, `sa_col_capture`, instantiated per column c with parameter C. It takes k and the strobe, computes r = k − S − C, range-checks it, and writes one X_R×16 column buffer.
- The top level owns the FSM, the k counter and the flattening to O_OUT.

## Test plan
All scenarios use S=4, X_R=3, N=4, so k_last = 9.
- Reset: assert I_RST mid-COLLECT → the next cycle shows O_OUT=0, VLD=0, BUSY=0, and subsequent I_SHIFT pulses are ignored.
- Nominal run: start, then 10 shift pulses with lane c driving the value 16'h(r<<4 | c) exactly when r=k−4−c is in range, and 16'hDEAD otherwise → VLD rises after pulse 9; O_OUT[(r*4+c)*16+:16] = r<<4|c for all r,c; no DEAD word appears.
- Gapped shifts: the same stimulus with I_SHIFT high only every 5th cycle → identical O_OUT; VLD rises one cycle after the 10th pulse.
- Restart mid-run: start, 5 pulses, start again, then 10 pulses carrying new data → VLD stays low until the 10th post-restart pulse; O_OUT contains only the new data.
- Simultaneous start+shift: start and shift high together, then 10 pulses → the first pulse is dropped and capture aligns to the following 10 pulses.
- Hold: after DONE, 20 extra shift pulses with random I_SA_OUT → O_OUT unchanged and VLD stays 1 until the next start.
